// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants
// and ALU operation encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOP
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: opcode/funct decode and
// integer datapath, fully combinational.
module alu_core
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] result,
  output logic        zero,
  output logic        rw
);

  alu_op_t alu_op;
  logic    is_r;

  assign is_r = (opcode == OP_RTYPE);

  // Decode instruction into ALU op and write enable
  always_comb begin
    alu_op = ALU_NOP;
    rw     = 1'b0;
    unique case (1'b1)
      is_r && (funct == FN_ADD): begin
        alu_op = ALU_ADD;
        rw     = 1'b1;
      end
      is_r && (funct == FN_SUB): begin
        alu_op = ALU_SUB;
        rw     = 1'b1;
      end
      is_r && (funct == FN_AND): begin
        alu_op = ALU_AND;
        rw     = 1'b1;
      end
      is_r && (funct == FN_OR): begin
        alu_op = ALU_OR;
        rw     = 1'b1;
      end
      opcode == OP_LW: begin
        alu_op = ALU_ADD;
        rw     = 1'b1;
      end
      opcode == OP_SW: begin
        alu_op = ALU_ADD;
      end
      opcode == OP_BEQ: begin
        alu_op = ALU_SUB;
      end
      default: begin
        alu_op = ALU_NOP;
      end
    endcase
  end

  // Datapath: arithmetic wraps modulo 2^32
  always_comb begin
    result = 32'h0;
    unique case (alu_op)
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/exec_pc_unit.sv
// exec_pc_unit: ALU plus PC register and
// next-PC adder with beq target select.
module exec_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] ext_imm,
  output logic [31:0] result,
  output logic        zero,
  output logic        rw,
  output logic [31:0] pc,
  output logic [31:0] newpc
);

  logic        alu_rw;
  logic        take;
  logic [31:0] br_off;
  logic [31:0] pc_d;
  logic [31:0] pc_q;

  alu_core u_alu (
    .opcode (opcode),
    .funct  (funct),
    .in1    (in1),
    .in2    (in2),
    .result (result),
    .zero   (zero),
    .rw     (alu_rw)
  );

  // Register writes are suppressed in reset
  assign rw = alu_rw & rst_n;

  // Next PC: sequential or word-offset beq target
  always_comb begin
    take   = (opcode == OP_BEQ) && zero;
    br_off = take ? (ext_imm << 2) : 32'h0;
    newpc  = pc_q + PC_STEP + br_off;
  end

  // PC update priority: reset, enable, hold
  always_comb begin
    pc_d = pc_q;
    if (!rst_n)
      pc_d = RESET_PC;
    else if (pc_en)
      pc_d = newpc;
  end

  // PC register, synchronous reset via pc_d
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_exec_pc_unit.sv
// tb_exec_pc_unit: directed steps with a
// scoreboard queue of expected outputs.
module tb_exec_pc_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] ext_imm;
  logic [31:0] result;
  logic        zero;
  logic        rw;
  logic [31:0] pc;
  logic [31:0] newpc;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        w;
    logic [31:0] p;
    logic [31:0] np;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec;
  int          n_err;
  logic [31:0] m_pc;

  exec_pc_unit #(.RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc_en   (pc_en),
    .opcode  (opcode),
    .funct   (funct),
    .in1     (in1),
    .in2     (in2),
    .ext_imm (ext_imm),
    .result  (result),
    .zero    (zero),
    .rw      (rw),
    .pc      (pc),
    .newpc   (newpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic        r,
    input logic [5:0]  op,
    input logic [5:0]  fn,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] imm,
    input logic [31:0] p);
    exp_t e;
    e.res = 32'h0;
    e.w   = 1'b0;
    if (op == 6'b000000) begin
      if (fn == 6'b100000) begin
        e.res = a + b; e.w = 1'b1;
      end else if (fn == 6'b100010) begin
        e.res = a - b; e.w = 1'b1;
      end else if (fn == 6'b100100) begin
        e.res = a & b; e.w = 1'b1;
      end else if (fn == 6'b100101) begin
        e.res = a | b; e.w = 1'b1;
      end
    end else if (op == 6'b100011) begin
      e.res = a + b; e.w = 1'b1;
    end else if (op == 6'b101011) begin
      e.res = a + b;
    end else if (op == 6'b000100) begin
      e.res = a - b;
    end
    if (!r) e.w = 1'b0;
    e.z  = (e.res == 32'h0);
    e.p  = p;
    e.np = p + 32'd4;
    if (op == 6'b000100 && e.z)
      e.np = e.np + {imm[29:0], 2'b00};
    return e;
  endfunction

  // One instruction cycle: drive, check, clock
  task automatic step(input string tag,
                      input logic r,
                      input logic en,
                      input logic [5:0] op,
                      input logic [5:0] fn,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] imm);
    exp_t e;
    rst_n = r; pc_en = en;
    opcode = op; funct = fn;
    in1 = a; in2 = b; ext_imm = imm;
    sbq.push_back(model(r, op, fn, a, b,
                        imm, m_pc));
    #1;
    e = sbq.pop_front();
    chk({tag, ".res"}, result, e.res);
    chk({tag, ".zero"}, {31'b0, zero},
        {31'b0, e.z});
    chk({tag, ".rw"}, {31'b0, rw},
        {31'b0, e.w});
    chk({tag, ".pc"}, pc, e.p);
    chk({tag, ".npc"}, newpc, e.np);
    @(posedge clk);
    if (!r) m_pc = 32'h0;
    else if (en) m_pc = e.np;
    #1;
  endtask

  task automatic nop(input string tag,
                     input logic r,
                     input logic en);
    step(tag, r, en, OP_RTYPE, FN_ADD,
         32'd0, 32'd0, 32'd0);
  endtask

  task automatic goto8();
    nop("g_rst", 1'b0, 1'b1);
    nop("g_s1", 1'b1, 1'b1);
    nop("g_s2", 1'b1, 1'b1);
    chk("at8", pc, 32'd8);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; pc_en = 1'b1;
    opcode = OP_RTYPE; funct = FN_ADD;
    in1 = 32'd5; in2 = 32'd7;
    ext_imm = 32'd0;
    @(posedge clk); #1;
    m_pc = 32'h0;
    chk("rst_pc", pc, 32'h0);
    step("rst_add", 1'b0, 1'b1, OP_RTYPE,
         FN_ADD, 32'd5, 32'd7, 32'd0);
    chk("rst_rw0", {31'b0, rw}, 32'd0);
    nop("s0", 1'b1, 1'b1);
    chk("pc4", pc, 32'd4);
    nop("s1", 1'b1, 1'b1);
    chk("pc8", pc, 32'd8);
    nop("s2", 1'b1, 1'b1);
    chk("pc12", pc, 32'd12);

    rst_n = 1'b1; opcode = OP_RTYPE;
    funct = FN_ADD; in1 = 32'd5;
    in2 = 32'd7; #1;
    chk("add_lit", result, 32'd12);
    step("add", 1'b1, 1'b1, OP_RTYPE,
         FN_ADD, 32'd5, 32'd7, 32'd0);
    step("sub", 1'b1, 1'b1, OP_RTYPE,
         FN_SUB, 32'd3, 32'd5, 32'd0);
    step("and", 1'b1, 1'b1, OP_RTYPE,
         FN_AND, 32'hF0F0, 32'h0FF0, 32'd0);
    step("or", 1'b1, 1'b1, OP_RTYPE,
         FN_OR, 32'hF0F0, 32'h0FF0, 32'd0);
    step("addwrap", 1'b1, 1'b1, OP_RTYPE,
         FN_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    step("lw", 1'b1, 1'b1, OP_LW, 6'd0,
         32'd100, 32'hFFFF_FFFC, 32'd0);
    step("sw", 1'b1, 1'b1, OP_SW, 6'd0,
         32'd100, 32'hFFFF_FFFC, 32'd0);

    goto8();
    step("beq_t", 1'b1, 1'b1, OP_BEQ, 6'd0,
         32'd9, 32'd9, 32'd3);
    chk("beq_t_pc", pc, 32'd24);
    goto8();
    step("beq_nt", 1'b1, 1'b1, OP_BEQ, 6'd0,
         32'd9, 32'd8, 32'd3);
    chk("beq_nt_pc", pc, 32'd12);
    goto8();
    step("beq_bk", 1'b1, 1'b1, OP_BEQ, 6'd0,
         32'd9, 32'd9, 32'hFFFF_FFFD);
    chk("beq_bk_pc", pc, 32'd0);

    nop("adv", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      nop("stall", 1'b1, 1'b0);
    chk("stall_pc", pc, 32'd4);
    step("self", 1'b1, 1'b1, OP_BEQ, 6'd0,
         32'd1, 32'd1, 32'hFFFF_FFFF);
    chk("self_pc", pc, 32'd4);

    step("rst_beq", 1'b0, 1'b1, OP_BEQ, 6'd0,
         32'd2, 32'd2, 32'd5);
    chk("rst_beq_pc", pc, 32'd0);
    nop("resume", 1'b1, 1'b1);
    chk("resume_pc", pc, 32'd4);
    nop("rst_hold", 1'b0, 1'b0);
    chk("rst_hold_pc", pc, 32'd0);

    step("ill_op", 1'b1, 1'b1, 6'b001000,
         6'd0, 32'd5, 32'd7, 32'd0);
    step("ill_fn", 1'b1, 1'b1, OP_RTYPE,
         6'b101010, 32'd5, 32'd7, 32'd0);
    chk("ill_pc", pc, 32'd8);

    nop("w_rst", 1'b0, 1'b1);
    step("to_top", 1'b1, 1'b1, OP_BEQ, 6'd0,
         32'd0, 32'd0, 32'hFFFF_FFFE);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    nop("wrap", 1'b1, 1'b1);
    chk("wrap_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
